// File: rtl/dwt_mac_scheduler.sv
// Round-robin scheduler that shares one pipelined MAC filter engine between the
// wavelet decomposition levels, tracking result tags and discarding warm-up results.
module dwt_mac_scheduler #(
  parameter int NUM_LEVELS  = 3,
  parameter int MAC_LATENCY = 3,
  parameter int WARMUP      = 2,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [NUM_LEVELS-1:0] level_en,
  input  logic                  halt,
  input  logic [NUM_LEVELS-1:0] req_valid,
  output logic [NUM_LEVELS-1:0] req_ready,
  output logic                  mac_issue_valid,
  output logic [SEL_WIDTH-1:0]  mac_issue_sel,
  output logic [NUM_LEVELS-1:0] res_valid,
  output logic [SEL_WIDTH-1:0]  res_tag,
  output logic [SEL_WIDTH:0]    inflight,
  output logic                  idle
);

  // Handshake: a block transfers from level i in any cycle where req_valid[i]
  // and req_ready[i] are both high; req_ready is one-hot or zero and never
  // depends on anything but registered state and the current-cycle inputs.

  localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0]      WARM_MAX  = CW'(WARMUP);
  localparam logic [SEL_WIDTH:0] LEVELS_W  = (SEL_WIDTH + 1)'(NUM_LEVELS);
  localparam logic [SEL_WIDTH-1:0] LAST_LVL = SEL_WIDTH'(NUM_LEVELS - 1);

  logic [NUM_LEVELS-1:0]  eligible;
  logic [NUM_LEVELS-1:0]  grant;
  logic [SEL_WIDTH-1:0]   gidx;
  logic                   any_grant;
  logic [SEL_WIDTH:0]     scan_idx;
  logic [SEL_WIDTH-1:0]   ptr;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [CW-1:0]          cnt [NUM_LEVELS];
  logic [CW-1:0]          cnt_eff;
  logic                   grant_discard;
  logic [MAC_LATENCY-1:0] pipe_v;
  logic [MAC_LATENCY-1:0] pipe_d;
  logic [SEL_WIDTH-1:0]   pipe_t [MAC_LATENCY];
  logic                   retire;

  // Rotating priority search starting at the pointer; rst_n gates grants so
  // req_ready reads zero for the whole time reset is held.
  always_comb begin
    eligible  = req_valid & level_en & {NUM_LEVELS{~halt & rst_n}};
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      scan_idx = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
      if (scan_idx >= LEVELS_W) scan_idx = scan_idx - LEVELS_W;
      if (!any_grant && eligible[scan_idx]) begin
        any_grant        = 1'b1;
        grant[scan_idx]  = 1'b1;
        gidx             = scan_idx[SEL_WIDTH-1:0];
      end
    end
  end

  // A frame_start in the grant cycle makes this grant the first block of the new frame.
  always_comb begin
    cnt_eff       = frame_start ? '0 : cnt[gidx];
    grant_discard = (cnt_eff < WARM_MAX);
  end

  assign retire          = pipe_v[MAC_LATENCY-1];
  assign req_ready       = grant;
  assign mac_issue_valid = any_grant;
  assign mac_issue_sel   = any_grant ? gidx : sel_q;
  assign idle            = (inflight == '0) && !any_grant;
  assign res_tag         = pipe_t[MAC_LATENCY-1];

  always_comb begin
    res_valid = '0;
    if (pipe_v[MAC_LATENCY-1] && !pipe_d[MAC_LATENCY-1])
      res_valid[pipe_t[MAC_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      sel_q    <= '0;
      pipe_v   <= '0;
      pipe_d   <= '0;
      inflight <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) pipe_t[i] <= '0;
      for (int i = 0; i < NUM_LEVELS; i++)  cnt[i]    <= '0;
    end else begin
      if (any_grant) begin
        ptr   <= (gidx == LAST_LVL) ? '0 : gidx + 1'b1;
        sel_q <= gidx;
      end

      // Tag pipeline mirrors the engine's issue-to-result latency.
      pipe_v[0] <= any_grant;
      pipe_d[0] <= any_grant & grant_discard;
      pipe_t[0] <= any_grant ? gidx : '0;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
        pipe_t[i] <= pipe_t[i-1];
      end

      case ({any_grant, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (frame_start) cnt[i] <= '0;
        if (any_grant && gidx == SEL_WIDTH'(i) && cnt_eff < WARM_MAX)
          cnt[i] <= cnt_eff + 1'b1;
      end
    end
  end

endmodule
